// File: rtl/clk_step_ctrl_if.sv
// Signal bundle between the run/step controller and its surroundings:
// slow clock, buttons and core handshake.
interface clk_step_ctrl_if #(
   parameter int unsigned CNT_W = 32
);
   logic             slow_clk;
   logic             btn_run;
   logic             btn_step;
   logic             halt_req;
   logic             clr_count;
   logic             proc_ce;
   logic [1:0]       mode;
   logic [CNT_W-1:0] ce_count;

   modport master (
      input  slow_clk, btn_run, btn_step, halt_req, clr_count,
      output proc_ce, mode, ce_count
   );

   modport slave (
      output slow_clk, btn_run, btn_step, halt_req, clr_count,
      input  proc_ce, mode, ce_count
   );
endinterface

// File: rtl/clk_step_ctrl.sv
// Run/step controller: turns the divided slow clock into single-cycle core
// enables, gated by debounced run/step buttons and the core halt request.
module clk_step_ctrl #(
   parameter int unsigned DEB_CYCLES = 4,
   parameter int unsigned CNT_W      = 32
) (
   input  logic             clk_in,
   input  logic             rst,
   clk_step_ctrl_if.master  bus
);

   localparam int unsigned     DEB_W    = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
   localparam logic [DEB_W-1:0] DEB_LAST = DEB_W'(DEB_CYCLES - 1);

   typedef enum logic [1:0] {
      ST_HALTED     = 2'b00,
      ST_RUN        = 2'b01,
      ST_STEP_ARMED = 2'b10
   } state_t;

   state_t           state;
   logic             slow_s0, slow_s1, slow_s1_d;
   logic             tick;
   logic [1:0]       btn_s0, btn_s1;   // bit 0 run, bit 1 step
   logic [1:0]       deb;
   logic [1:0]       press;
   logic [DEB_W-1:0] deb_cnt [2];
   logic             proc_ce;
   logic [CNT_W-1:0] ce_count;
   logic             run_p, step_p;
   logic             issue_c;

   assign run_p  = press[0];
   assign step_p = press[1];

   // A run press in the same cycle as a tick leaves RUN/arms a mode change, so it suppresses issue
   assign issue_c = tick & ~bus.halt_req & ~run_p &
                    ((state == ST_RUN) | (state == ST_STEP_ARMED));

   always_ff @(posedge clk_in) begin
      if (rst) begin
         state     <= ST_HALTED;
         slow_s0   <= 1'b0;
         slow_s1   <= 1'b0;
         slow_s1_d <= 1'b0;
         tick      <= 1'b0;
         btn_s0    <= '0;
         btn_s1    <= '0;
         deb       <= '0;
         press     <= '0;
         for (int i = 0; i < 2; i++) deb_cnt[i] <= '0;
         proc_ce   <= 1'b0;
         ce_count  <= '0;
      end else begin
         slow_s0   <= bus.slow_clk;
         slow_s1   <= slow_s0;
         slow_s1_d <= slow_s1;
         tick      <= slow_s1 & ~slow_s1_d;

         btn_s0 <= {bus.btn_step, bus.btn_run};
         btn_s1 <= btn_s0;

         // Level must differ for DEB_CYCLES consecutive cycles before it is accepted
         for (int i = 0; i < 2; i++) begin
            press[i] <= 1'b0;
            if (btn_s1[i] == deb[i]) begin
               deb_cnt[i] <= '0;
            end else if (deb_cnt[i] == DEB_LAST) begin
               deb[i]     <= btn_s1[i];
               deb_cnt[i] <= '0;
               press[i]   <= btn_s1[i];
            end else begin
               deb_cnt[i] <= deb_cnt[i] + DEB_W'(1);
            end
         end

         proc_ce <= issue_c;

         if (bus.clr_count) begin
            ce_count <= '0;
         end else if (issue_c && (ce_count != {CNT_W{1'b1}})) begin
            ce_count <= ce_count + CNT_W'(1);
         end

         if (bus.halt_req) begin
            state <= ST_HALTED;
         end else begin
            case (state)
               ST_HALTED: begin
                  if (run_p)       state <= ST_RUN;
                  else if (step_p) state <= ST_STEP_ARMED;
               end
               ST_RUN: begin
                  if (run_p) state <= ST_HALTED;
               end
               ST_STEP_ARMED: begin
                  if (run_p)     state <= ST_RUN;
                  else if (tick) state <= ST_HALTED;
               end
               default: state <= ST_HALTED;
            endcase
         end
      end
   end

   assign bus.proc_ce  = proc_ce;
   assign bus.mode     = state;
   assign bus.ce_count = ce_count;

endmodule
